// File: rtl/disp_pkg.sv
// Shared BCD types and constants for the counter and the seven-segment scan stage.
package disp_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef bcd_digit_t [DIGITS-1:0] bcd_word_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Non-decimal codes (A-F) are forced to 9 so the display never shows garbage.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with parallel load and up/down step; cout is the carry or borrow
// into the next more-significant digit.
module bcd_digit
    import disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dir,
    input  logic       cin,
    input  logic       load_en,
    input  logic [3:0] load_d,
    output logic [3:0] q,
    output logic       cout
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = bcd_clamp(load_d);
        end else if (cin) begin
            if (dir) begin
                q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
            end else begin
                q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Combinational so the carry/borrow ripples through all digits in one cycle.
    assign cout = cin & (dir ? (q_q >= BCD_MAX) : (q_q == 4'd0));
    assign q    = q_q;

endmodule

// File: rtl/bcd_counter_4d.sv
// Four-digit BCD up/down counter with tick prescaler, synchronised run/stop toggle
// and clamped parallel load, feeding the seven-segment scan multiplexer.
module bcd_counter_4d
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_btn,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tick_q, tick_d;
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic btn_prev_q, btn_prev_d;
    logic running_q, running_d;
    logic wrap_q, wrap_d;

    logic            step_en;
    logic [DIGITS:0] carry;
    bcd_word_t       digit_q;
    bcd_word_t       load_word;

    assign load_word = bcd_word_t'(load_val);
    assign step_en   = tick_q & running_q & ~load;
    assign carry[0]  = step_en;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk     (clk),
                .rst     (rst),
                .dir     (up),
                .cin     (carry[gi]),
                .load_en (load),
                .load_d  (load_word[gi]),
                .q       (digit_q[gi]),
                .cout    (carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d     = (cnt_q == CNT_LAST);
        sync1_d    = run_btn;
        sync2_d    = sync1_q;
        btn_prev_d = sync2_q;
        // Only the synchronised rising edge toggles; a held button does nothing more.
        running_d  = running_q ^ (sync2_q & ~btn_prev_q);
        wrap_d     = step_en & carry[DIGITS];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_prev_q <= 1'b0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            btn_prev_q <= btn_prev_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    assign value   = digit_q;
    assign running = running_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/bcd_counter_4d.md
# bcd_counter_4d

Four-digit BCD up/down counter that produces the 16-bit packed value consumed by the 4-digit seven-segment scan multiplexer: digit 3 (most significant) in bits [15:12], digit 0 in bits [3:0]. It contains its own tick prescaler, a synchronised start/stop toggle input and a synchronous parallel load. It sits directly upstream of the display stage, and its `value` output connects to that stage's 16-bit data input.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per count tick; 1 Hz at 100 MHz. Must be ≥2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `run_btn`  in  1  asynchronous level from a debounced button; each rising edge toggles run/stop.
- `up`  in  1  count direction: 1 = increment, 0 = decrement; sampled on each tick.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  16  packed BCD load value, same digit order as `value`.
- `value`  out  16  packed BCD count, registered.
- `running`  out  1  1 = counting enabled.
- `tick`  out  1  one-cycle pulse per prescaler period.
- `wrap`  out  1  one-cycle pulse on 9999→0000 or 0000→9999.

## Operation
- Reset values while `rst`=1: `value`=16'h0000, `running`=0, `tick`=0, `wrap`=0, prescaler=0, synchroniser and edge registers=0.
- Prescaler:
  - Free-runs 0..TICK_DIV-1 whether or not the counter is running, then returns to 0.
  - `tick` is registered. It is high for exactly one cycle, the cycle after the prescaler reaches TICK_DIV-1, so it pulses once every TICK_DIV cycles.
  - Neither `load` nor `running` affects the prescaler.
- Run control:
  - `run_btn` passes through a 2-FF synchroniser, then a rising-edge detector.
  - Each detected edge inverts `running`. Holding the input high does not repeat the toggle.
  - No debounce inside the block.
- Count step: on a cycle where `tick`=1 and `running`=1 and `load`=0:
  - `up`=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - `up`=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - Carry and borrow ripple combinationally through all four digits within the one cycle.
- Wrap:
  - Carry out of digit 3 (9999→0000) or borrow out of digit 3 (0000→9999) sets `wrap`=1 on the same edge that updates `value`.
  - `wrap` clears the following cycle.
- Load:
  - `load`=1 writes `load_val` into `value` on the next edge.
  - Any load digit >9 is stored as 9.
  - Load has priority over a simultaneous step. That tick's step is discarded and `wrap` stays 0.
  - Load works whether running or stopped.
- When stopped, `value` holds and `tick` keeps pulsing.
- Reset mid-operation: every register returns to its reset value immediately, and the first tick after release arrives TICK_DIV cycles later.

## Timing
- Step latency: with `tick` high in cycle N, the new `value` is visible in cycle N+1, with `wrap` in the same cycle N+1.
- Load latency: `load` sampled at edge N; `value` equals the clamped `load_val` from cycle N+1.
- Button latency: an `run_btn` rise settling before edge N toggles `running` at edge N+2, visible in cycle N+2 (2 sync flops plus the edge/toggle register).
- Outputs are all registered. No combinational path from any input to any output.
- Throughput: at most one step per TICK_DIV cycles.

## Structure
- Shared package `disp_pkg`:
  - `DIGITS`=4, `DIGIT_W`=4, `BCD_MAX`=4'd9.
  - Type `bcd_digit_t` (logic [3:0]).
  - Packed type `bcd_word_t` (array [DIGITS-1:0] of `bcd_digit_t`, 16 bits).
  - The display multiplexer reuses this package.
- Sub-module `bcd_digit`, instantiated four times in a chain:
  - Inputs: `dir`, `cin` (carry or borrow in), `load_en`, `load_d`.
  - Outputs: registered `q`, combinational `cout`.
  - Digit 0 `cin` = `tick & running & ~load`.
- Prescaler, synchroniser/edge detector, `running` toggle and `wrap` register live in the top module.

## Test plan
All scenarios use TICK_DIV=4.
- Reset check: hold `rst` 3 cycles -> all outputs 0. Release -> first `tick` exactly 4 cycles later, then every 4 cycles.
- Run toggle: pulse `run_btn` 0→1 for 5 cycles -> `running`=1 two edges after the rise, one toggle only. Second pulse -> `running`=0 and `value` frozen.
- Up count with carry: load 16'h0198, `up`=1, running -> sequence 0199, 0200, 0201, one step per tick.
- Up wrap: load 16'h9999, `up`=1 -> next tick gives `value`=0000 with `wrap`=1 for exactly one cycle.
- Down wrap: load 16'h0000, `up`=0 -> next tick gives `value`=9999 with `wrap`=1. Then 9998, then 9997.
- Load/step collision and clamp: assert `load` with `load_val`=16'h3A5F in a `tick` cycle while running -> `value`=3959, no step, `wrap`=0. Next tick steps normally. Also assert `rst` mid-count -> `value`=0000 immediately (asynchronous).
